gate_mul4_vec: RTL and testbench
================================

Name: gate_mul4_vec

Overview:
- Four-lane gating multiplier that sits directly downstream of the sigmoid LUT stage in the Mamba gate path.
- Joins two streams: the sigmoid output (Q0.16 unsigned) and the matching raw activation tile (Q8.8 signed, from the activation FIFO).
- Produces y = x * sigmoid(x), i.e. the SiLU-gated value, in Q8.8.
- Pipelined multiply feeds an internal output FIFO, so in_ready never depends combinationally on out_ready.

Parameters:
- TILE_SIZE, 4, number of lanes; only 4 is supported, error otherwise.
- X_W, 16, activation width, Q8.8 signed.
- SIG_W, 16, sigmoid width, Q0.16 unsigned.
- OUT_W, 16, result width, Q8.8 signed.
- OUT_DEPTH, 4, output FIFO entries; values below 2 are an elaboration error, and 4 or more is needed for 1 token/cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- sig_valid  in  1  sigmoid tile valid.
- sig_ready  out  1  sigmoid tile accepted.
- sig_vec  in  TILE_SIZE x SIG_W  sigmoid values, Q0.16 unsigned.
- x_valid  in  1  activation tile valid.
- x_ready  out  1  activation tile accepted.
- x_vec  in  TILE_SIZE x X_W  activations, Q8.8 signed.
- out_valid  out  1  result tile valid.
- out_ready  in  1  downstream accepts.
- out_vec  out  TILE_SIZE x OUT_W  gated result, Q8.8 signed.

Behaviour:
- Single clock domain. rst is synchronous and active-high; it is the only reset.
- Join handshake:
  - space = (s1_valid + s2_valid + fifo_count) < OUT_DEPTH, computed from registered state only.
  - sig_ready = x_ready = space && sig_valid && x_valid.
  - fire = sig_valid && x_valid && space. One side never fires without the other.
- Skewed arrivals: a lone valid stream waits. Its data must be held stable by the producer per ready/valid rules.
- S1 (cycle after fire): per lane, p = x × {1'b0, sig}, a 33-bit signed product in Q8.24.
- S2:
  - r = (p + 2^15) >>> 16, arithmetic shift, round-half-up.
  - Saturate r to [-32768, 32767]. Saturation is unreachable for legal inputs but must be present.
  - Take the low OUT_W bits.
- FIFO write: the S2 result is written to the FIFO tail unconditionally. The space accounting guarantees no overflow; an overflow is an assertion failure.
- Latency: fire in cycle N gives out_valid in cycle N+3 if the FIFO was empty.
- Output:
  - out_vec = FIFO head, forced to 0 when the FIFO is empty.
  - out_valid = FIFO non-empty.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave the count unchanged.
- Throughput:
  - With out_ready held high and OUT_DEPTH ≥ 4, one tile per cycle is sustained.
  - With out_ready low, acceptance stops after exactly OUT_DEPTH tiles are in flight or stored.
- Ordering: strict FIFO order. No token is lost or duplicated.
- Reset values (also apply when rst asserts mid-operation, in the next cycle):
  - s1_valid, s2_valid, FIFO pointers and count go to 0.
  - out_valid, sig_ready and x_ready read 0, and out_vec reads 0.
  - In-flight tokens are discarded.
- Pointer wrap: read and write pointers wrap modulo OUT_DEPTH. OUT_DEPTH is not required to be a power of two.

Optional Feature:
- Macro: GATE_MUL_ROUND_EN.
- Defined: S2 rounds half-up, adding 2^15 before the shift, as above.
- Undefined: S2 truncates (floor, plain >>> 16, no add).
- Latency, handshake and saturation are unchanged in both cases.

Decomposition:
- Shared package mamba_fx_pkg holds:
  - TILE_SIZE;
  - Q8.8 and Q0.16 widths and fractional-bit constants (FRAC_X=8, FRAC_SIG=16);
  - rounding constant 2^15;
  - saturation limits;
  - a lane-vector typedef for Q8.8 and one for Q0.16.
- One sub-module, vec_fifo: a synchronous FIFO parameterized by width and depth, exposing count, show-ahead head and sync reset. The multiply and round logic stays in gate_mul4_vec.

Test Plan:
- Basic values, all lanes:
  - x=0x0100 (1.0), sig=0x8000 (0.5) → 0x0080.
  - x=0xFF00 (-1.0), sig=0x8000 → 0xFF80.
  - x=0x7FFF, sig=0xFFFF → 0x7FFF.
  - First out_valid exactly 3 cycles after fire.
- Rounding:
  - x=0x0001, sig=0x8000 → 0x0001 with GATE_MUL_ROUND_EN, 0x0000 without.
  - x=0xFFFF, sig=0x8000 → 0x0000 with, 0xFFFF without.
- Skewed join: x_valid high at cycle 0, sig_valid rises at cycle 3 → no ready/fire before cycle 3, single fire at cycle 3, one result.
- Backpressure:
  - Offer 8 tiles with out_ready=0 → exactly 4 accepted, then ready stays low.
  - Raise out_ready → 8 results in order, values match the model, no gaps once streaming at full rate.
- Reset mid-stream: assert rst for 1 cycle with 2 tokens in S1/S2 and 1 in the FIFO → next cycle out_valid=0, out_vec=0, readies low. Post-reset stream starts cleanly with latency 3.
- Random stress: 10k random tiles with random valid/ready toggling → scoreboard matches the bit-exact model, no overflow assertion fires.

Source files
------------

// File: rtl/mamba_fx_pkg.sv
// mamba_fx_pkg: shared fixed-point widths, rounding/saturation constants and lane vector types for the Mamba gate path
package mamba_fx_pkg;
  localparam int TILE_SIZE = 4;
  localparam int X_W = 16;
  localparam int SIG_W = 16;
  localparam int OUT_W = 16;
  localparam int FRAC_X = 8;
  localparam int FRAC_SIG = 16;
  localparam int RND_HALF = 1 << (FRAC_SIG - 1);
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;
  typedef logic [TILE_SIZE-1:0][X_W-1:0] q8_8_vec_t;
  typedef logic [TILE_SIZE-1:0][SIG_W-1:0] q0_16_vec_t;
endpackage

// File: rtl/vec_fifo.sv
// vec_fifo: synchronous show-ahead FIFO with occupancy count; depth need not be a power of two
module vec_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic pop_en;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign pop_en = pop && (count != '0);
  assign head = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop_en) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop_en);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !pop_en && count == CW'(DEPTH)));
endmodule

// File: rtl/gate_mul4_vec.sv
// gate_mul4_vec: four-lane SiLU gating multiply x*sigmoid(x) with join handshake and output FIFO; GATE_MUL_ROUND_EN selects round-half-up over floor
module gate_mul4_vec #(
  parameter int TILE_SIZE = mamba_fx_pkg::TILE_SIZE,
  parameter int X_W = mamba_fx_pkg::X_W,
  parameter int SIG_W = mamba_fx_pkg::SIG_W,
  parameter int OUT_W = mamba_fx_pkg::OUT_W,
  parameter int OUT_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sig_valid,
  output logic                            sig_ready,
  input  logic [TILE_SIZE-1:0][SIG_W-1:0] sig_vec,
  input  logic                            x_valid,
  output logic                            x_ready,
  input  logic [TILE_SIZE-1:0][X_W-1:0]   x_vec,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [TILE_SIZE-1:0][OUT_W-1:0] out_vec
);
  import mamba_fx_pkg::*;
  localparam int PW = X_W + SIG_W + 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
`ifdef GATE_MUL_ROUND_EN
  localparam logic signed [PW-1:0] ADD = PW'(RND_HALF);
`else
  localparam logic signed [PW-1:0] ADD = '0;
`endif
  localparam logic signed [PW-1:0] HI = PW'(SAT_MAX);
  localparam logic signed [PW-1:0] LO = PW'(SAT_MIN);
  if (TILE_SIZE != 4) begin : g_bad_tile
    $error("gate_mul4_vec: TILE_SIZE must be 4");
  end
  if (OUT_DEPTH < 2) begin : g_bad_depth
    $error("gate_mul4_vec: OUT_DEPTH must be at least 2");
  end
  logic s1_valid, s2_valid, space, fire, pop;
  logic signed [PW-1:0] s1_p [TILE_SIZE];
  q8_8_vec_t y, s2_y, head;
  logic [CW-1:0] fifo_count;
  assign space = (int'(s1_valid) + int'(s2_valid) + int'(fifo_count)) < OUT_DEPTH;
  assign fire = !rst && sig_valid && x_valid && space;
  assign sig_ready = fire;
  assign x_ready = fire;
  for (genvar i = 0; i < TILE_SIZE; i++) begin : g_lane
    logic signed [PW-1:0] r;
    assign r = (s1_p[i] + ADD) >>> FRAC_SIG;
    assign y[i] = (r > HI) ? HI[OUT_W-1:0] : (r < LO) ? LO[OUT_W-1:0] : r[OUT_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= fire;
      s2_valid <= s1_valid;
    end
  end
  always_ff @(posedge clk) begin
    if (fire)
      for (int i = 0; i < TILE_SIZE; i++)
        s1_p[i] <= $signed(x_vec[i]) * $signed({1'b0, sig_vec[i]});
    if (s1_valid) s2_y <= y;
  end
  vec_fifo #(.W(TILE_SIZE * OUT_W), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(s2_valid),
    .din(s2_y),
    .pop(pop),
    .head(head),
    .count(fifo_count)
  );
  assign out_valid = fifo_count != '0;
  assign pop = out_valid && out_ready;
  assign out_vec = out_valid ? head : '0;
endmodule

// File: tb/tb_gate_mul4_vec.sv
// tb_gate_mul4_vec: directed and randomized checks of gate_mul4_vec against an arithmetic reference model
module tb_gate_mul4_vec;
  localparam int OUT_DEPTH = 4;
`ifdef GATE_MUL_ROUND_EN
  localparam logic [15:0] Y_MAX = 16'h7FFF, Y_RPOS = 16'h0001, Y_RNEG = 16'h0000;
`else
  localparam logic [15:0] Y_MAX = 16'h7FFE, Y_RPOS = 16'h0000, Y_RNEG = 16'hFFFF;
`endif
  logic clk = 1'b0, rst = 1'b1, sig_valid = 1'b0, x_valid = 1'b0, out_ready = 1'b0;
  logic sig_ready, x_ready, out_valid;
  logic [63:0] sig_vec = '0, x_vec = '0, out_vec;
  int checks = 0, errors = 0, n_out = 0;
  logic s_sr, s_xr, s_ov;
  logic [63:0] s_vec, last_out;
  bit fired;
  logic [63:0] q[$];
  logic [63:0] bp [8];

  gate_mul4_vec dut (
    .clk(clk),
    .rst(rst),
    .sig_valid(sig_valid),
    .sig_ready(sig_ready),
    .sig_vec(sig_vec),
    .x_valid(x_valid),
    .x_ready(x_ready),
    .x_vec(x_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_vec(out_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  function automatic logic [63:0] model(logic [63:0] xv, logic [63:0] sv);
    logic [63:0] y;
    longint p;
    for (int i = 0; i < 4; i++) begin
      p = longint'($signed(xv[16*i +: 16])) * longint'(sv[16*i +: 16]);
`ifdef GATE_MUL_ROUND_EN
      p = p + 32768;
`endif
      p = p >>> 16;
      if (p > 32767) p = 32767;
      else if (p < -32768) p = -32768;
      y[16*i +: 16] = p[15:0];
    end
    return y;
  endfunction

  task automatic tick();
    bit e;
    @(negedge clk);
    s_sr = sig_ready;
    s_xr = x_ready;
    s_ov = out_valid;
    s_vec = out_vec;
    e = !rst && sig_valid && x_valid && (q.size() < OUT_DEPTH);
    chk("ready", {62'd0, s_sr, s_xr}, {62'd0, e, e});
    if (!s_ov) chk("idle_zero", s_vec, 64'd0);
    if (s_ov && out_ready) begin
      n_out++;
      last_out = s_vec;
      if (q.size() == 0) chk("spurious", {63'd0, s_ov}, 64'd0);
      else chk("stream", s_vec, q.pop_front());
    end
    if (e) q.push_back(model(x_vec, sig_vec));
    fired = e;
    @(posedge clk);
    #1;
    if (rst) q.delete();
  endtask

  task automatic run_tile(string tag, logic [15:0] xl, logic [15:0] sl, logic [15:0] yl);
    int k;
    int n0;
    x_vec = {4{xl}};
    sig_vec = {4{sl}};
    x_valid = 1'b1;
    sig_valid = 1'b1;
    out_ready = 1'b1;
    n0 = n_out;
    tick();
    chk({tag, "_fire"}, {63'd0, s_sr}, 64'd1);
    x_valid = 1'b0;
    sig_valid = 1'b0;
    for (k = 1; k <= 10; k++) begin
      tick();
      if (n_out != n0) break;
    end
    chk({tag, "_latency"}, 64'(k), 64'd3);
    chk({tag, "_value"}, last_out, {4{yl}});
  endtask

  initial begin
    int n0, acc, c, sent;
    tick();
    x_valid = 1'b1;
    sig_valid = 1'b1;
    tick();
    rst = 1'b0;
    x_valid = 1'b0;
    sig_valid = 1'b0;
    tick();
    chk("reset_out_valid", {63'd0, s_ov}, 64'd0);
    chk("reset_out_vec", s_vec, 64'd0);

    run_tile("one_x_half", 16'h0100, 16'h8000, 16'h0080);
    run_tile("neg_one_x_half", 16'hFF00, 16'h8000, 16'hFF80);
    run_tile("max_x_max", 16'h7FFF, 16'hFFFF, Y_MAX);
    run_tile("round_pos", 16'h0001, 16'h8000, Y_RPOS);
    run_tile("round_neg", 16'hFFFF, 16'h8000, Y_RNEG);

    n0 = n_out;
    out_ready = 1'b1;
    x_vec = 64'h0123_8000_F789_7FFF;
    sig_vec = {$urandom, $urandom};
    x_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("skew_wait", {62'd0, s_sr, s_xr}, 64'd0);
    end
    sig_valid = 1'b1;
    tick();
    chk("skew_fire", {62'd0, s_sr, s_xr}, 64'd3);
    x_valid = 1'b0;
    sig_valid = 1'b0;
    repeat (8) tick();
    chk("skew_one_result", 64'(n_out - n0), 64'd1);

    for (int i = 0; i < 8; i++) bp[i] = {$urandom, $urandom};
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      x_valid = acc < 8;
      sig_valid = acc < 8;
      x_vec = bp[acc % 8];
      sig_vec = ~bp[acc % 8];
      tick();
      if (fired) acc++;
    end
    chk("bp_accepted", 64'(acc), 64'd4);
    chk("bp_stalled", {62'd0, s_sr, s_xr}, 64'd0);
    out_ready = 1'b1;
    n0 = n_out;
    c = 0;
    while (n_out - n0 < 8 && c < 40) begin
      x_valid = acc < 8;
      sig_valid = acc < 8;
      x_vec = bp[acc % 8];
      sig_vec = ~bp[acc % 8];
      tick();
      c++;
      if (fired) acc++;
    end
    chk("bp_drain_cycles", 64'(c), 64'd8);
    chk("bp_drain_count", 64'(n_out - n0), 64'd8);
    x_valid = 1'b0;
    sig_valid = 1'b0;

    out_ready = 1'b0;
    x_valid = 1'b1;
    sig_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x_vec = {$urandom, $urandom};
      sig_vec = {$urandom, $urandom};
      tick();
      chk("pre_reset_fire", {63'd0, s_sr}, 64'd1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    x_valid = 1'b0;
    sig_valid = 1'b0;
    tick();
    chk("midrst_out_valid", {63'd0, s_ov}, 64'd0);
    chk("midrst_out_vec", s_vec, 64'd0);
    chk("midrst_ready", {62'd0, s_sr, s_xr}, 64'd0);
    out_ready = 1'b1;
    n0 = n_out;
    repeat (5) tick();
    chk("midrst_flushed", 64'(n_out - n0), 64'd0);
    run_tile("post_reset", 16'h0200, 16'h4000, 16'h0080);

    sent = 0;
    c = 0;
    fired = 1'b0;
    while (sent < 10000 && c < 80000) begin
      if (!sig_valid || fired) begin
        sig_valid = $urandom_range(0, 9) < 7;
        sig_vec = {$urandom, $urandom};
      end
      if (!x_valid || fired) begin
        x_valid = $urandom_range(0, 9) < 7;
        x_vec = {$urandom, $urandom};
      end
      out_ready = $urandom_range(0, 9) < 7;
      tick();
      c++;
      if (fired) sent++;
    end
    chk("stress_sent", 64'(sent), 64'd10000);
    x_valid = 1'b0;
    sig_valid = 1'b0;
    out_ready = 1'b1;
    c = 0;
    while (q.size() != 0 && c < 50) begin
      tick();
      c++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
